// File: rtl/bus_ready_gen.sv
// 8088 READY / wait-state generator: picks a wait count from the latched chip selects,
// synchronises the peripheral ready and bounds every wait with a watchdog.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no bus cycle in progress, waiting for ALE
// ST_ARMED  | wait count latched, waiting for RD_N/WR_N
// ST_WAIT   | READY held low, counting wait clocks and watchdog
// ST_HOLD   | READY high, waiting for the strobe to end
module bus_ready_gen #(
   parameter int WAIT_CS1 = 0,
   parameter int WAIT_CS2 = 1,
   parameter int WAIT_CS3 = 2,
   parameter int WAIT_CS4 = 3,
   parameter int WAIT_DEF = 0,
   parameter int TIMEOUT  = 64,
   parameter int CW       = 8
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       ALE,
   input  logic       RD_N,
   input  logic       WR_N,
   input  logic [3:0] CS,
   input  logic       EXT_RDY,
   output logic       READY,
   output logic       WAIT_ACT,
   output logic       BUS_ERR
);

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_WAIT, ST_HOLD} state_t;

   localparam logic [CW-1:0] TMR_LOAD = CW'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   wcnt_q, wcnt_d;
   logic [CW-1:0]   tmr_q, tmr_d;
   logic            ready_q, ready_d;
   logic            wait_act_q, wait_act_d;
   logic            bus_err_q, bus_err_d;
   logic            sync1_q, rdy_s_q;
   logic [CW-1:0]   sel_wait;
   logic            cmd;

   always_comb begin
      if (CS[3])      sel_wait = CW'(WAIT_CS1);
      else if (CS[2]) sel_wait = CW'(WAIT_CS2);
      else if (CS[1]) sel_wait = CW'(WAIT_CS3);
      else if (CS[0]) sel_wait = CW'(WAIT_CS4);
      else            sel_wait = CW'(WAIT_DEF);
   end

   assign cmd = ~RD_N | ~WR_N;

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      tmr_d      = tmr_q;
      ready_d    = ready_q;
      wait_act_d = wait_act_q;
      bus_err_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ALE) begin
               wcnt_d  = sel_wait;
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (cmd) begin
               if (wcnt_q != '0 || !rdy_s_q) begin
                  // The entry edge is the first wait clock, so it consumes one count.
                  ready_d    = 1'b0;
                  wait_act_d = 1'b1;
                  tmr_d      = TMR_LOAD;
                  wcnt_d     = (wcnt_q != '0) ? wcnt_q - CW'(1) : '0;
                  state_d    = ST_WAIT;
               end else begin
                  ready_d = 1'b1;
                  state_d = ST_HOLD;
               end
            end else if (ALE) begin
               wcnt_d = sel_wait;
            end
         end
         ST_WAIT: begin
            if (!cmd) begin
               ready_d    = 1'b1;
               wait_act_d = 1'b0;
               wcnt_d     = '0;
               state_d    = ST_IDLE;
            end else if (wcnt_q == '0 && rdy_s_q) begin
               ready_d    = 1'b1;
               wait_act_d = 1'b0;
               state_d    = ST_HOLD;
            end else if (tmr_q == '0) begin
               ready_d    = 1'b1;
               wait_act_d = 1'b0;
               bus_err_d  = 1'b1;
               state_d    = ST_HOLD;
            end else begin
               wcnt_d = (wcnt_q != '0) ? wcnt_q - CW'(1) : '0;
               tmr_d  = tmr_q - CW'(1);
            end
         end
         ST_HOLD: begin
            ready_d = 1'b1;
            if (!cmd) state_d = ST_IDLE;
         end
         default: begin
            state_d    = ST_IDLE;
            ready_d    = 1'b1;
            wait_act_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ST_IDLE;
         wcnt_q     <= '0;
         tmr_q      <= '0;
         ready_q    <= 1'b1;
         wait_act_q <= 1'b0;
         bus_err_q  <= 1'b0;
         sync1_q    <= 1'b1;
         rdy_s_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         tmr_q      <= tmr_d;
         ready_q    <= ready_d;
         wait_act_q <= wait_act_d;
         bus_err_q  <= bus_err_d;
         sync1_q    <= EXT_RDY;
         rdy_s_q    <= sync1_q;
      end
   end

   assign READY    = ready_q;
   assign WAIT_ACT = wait_act_q;
   assign BUS_ERR  = bus_err_q;

endmodule
